tv_sync_sep: RTL and testbench

//  Composite-sync separator feeding the TV trigger stage: digitised active-low csync in,

---
 rtl/tv_sync_sep.sv | 256 +++++++++++++++++++++++++
 tb/tb_tv_sync_sep.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tv_sync_sep.sv
// tv_sync_sep: composite-sync separator giving line sync, field sync, field parity and line lock.
// Optional glitch filter on the synchronised csync is enabled by defining TV_SYNC_GLITCH_FILT_EN.
module tv_sync_sep #(
  parameter int unsigned FILT_LEN   = 3,
  parameter int unsigned EQ_MAX     = 32,
  parameter int unsigned HS_MAX     = 80,
  parameter int unsigned BROAD_MIN  = 150,
  parameter int unsigned LINE_PAL   = 640,
  parameter int unsigned LINE_NTSC  = 635,
  parameter int unsigned LINE_TOL   = 16,
  parameter int unsigned LOCK_LINES = 8
) (
  input  logic clk_in10M,
  input  logic rst_n,
  input  logic csync_in,
  input  logic video_mode,
  output logic hs_out,
  output logic vs_out,
  output logic oe_out,
  output logic locked
);
  typedef enum logic {P_IDLE = 1'b0, P_LOW = 1'b1} pstate_t;
  typedef enum logic [1:0] {V_NORM = 2'd0, V_PRE = 2'd1, V_BROAD = 2'd2, V_POST = 2'd3} vstate_t;
  typedef enum logic [1:0] {C_EQ = 2'd0, C_HS = 2'd1, C_BROAD = 2'd2, C_INV = 2'd3} cls_t;

  localparam logic [11:0] CNT_MAX  = 12'hFFF;
  localparam logic [11:0] EQ_W     = 12'(EQ_MAX);
  localparam logic [11:0] HS_W     = 12'(HS_MAX);
  localparam logic [11:0] BR_W     = 12'(BROAD_MIN);
  localparam logic [11:0] NOM_PAL  = 12'(LINE_PAL);
  localparam logic [11:0] NOM_NTSC = 12'(LINE_NTSC);
  localparam logic [12:0] TOL      = 13'(LINE_TOL);
  localparam logic [7:0]  LOCK_N   = 8'(LOCK_LINES);

  logic    sync1_q, sync2_q, s_sync;
  pstate_t pstate_q, pstate_d;
  vstate_t vstate_q, vstate_d;
  logic [11:0] wcnt_q, wcnt_d, pcnt_q, pcnt_d, period_q, period_d;
  logic        have_fall_q, have_fall_d, period_ok_q, period_ok_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [7:0]  lcnt_q, lcnt_d;
  logic        field_q, field_d, mode_q, mode_d;
  logic        hs_q, hs_d, vs_q, vs_d, oe_q, oe_d, locked_q, locked_d;
  logic [11:0] nom;
  logic        in_tol, field_odd, timeout;
  cls_t        cls;

`ifdef TV_SYNC_GLITCH_FILT_EN
  localparam logic [7:0] FILT_N = 8'(FILT_LEN);
  logic       s_sync_q, s_sync_d;
  logic [7:0] filt_cnt_q, filt_cnt_d;

  // A new level is accepted only after it has persisted FILT_LEN consecutive clocks.
  always_comb begin
    s_sync_d   = s_sync_q;
    filt_cnt_d = 8'd0;
    if (sync2_q != s_sync_q) begin
      if ((filt_cnt_q + 8'd1) >= FILT_N) begin
        s_sync_d   = sync2_q;
        filt_cnt_d = 8'd0;
      end else begin
        filt_cnt_d = filt_cnt_q + 8'd1;
      end
    end else begin
      filt_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk_in10M or negedge rst_n) begin
    if (!rst_n) begin
      s_sync_q   <= 1'b1;
      filt_cnt_q <= 8'd0;
    end else begin
      s_sync_q   <= s_sync_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  assign s_sync = s_sync_q;
`else
  logic [7:0] unused_filt_len;
  assign unused_filt_len = 8'(FILT_LEN);
  assign s_sync          = sync2_q;
`endif

  assign nom       = video_mode ? NOM_NTSC : NOM_PAL;
  assign in_tol    = (({1'b0, period_q} + TOL) >= {1'b0, nom}) && ({1'b0, period_q} <= ({1'b0, nom} + TOL));
  assign field_odd = ({2'b00, period_q} << 2) >= ({2'b00, nom} * 14'd3);
  assign timeout   = {1'b0, pcnt_q} >= {nom, 1'b0};

  always_comb begin
    pstate_d    = pstate_q;
    vstate_d    = vstate_q;
    wcnt_d      = wcnt_q;
    pcnt_d      = (pcnt_q == CNT_MAX) ? pcnt_q : pcnt_q + 12'd1;
    period_d    = period_q;
    have_fall_d = have_fall_q;
    period_ok_d = period_ok_q;
    bcnt_d      = bcnt_q;
    lcnt_d      = lcnt_q;
    field_d     = field_q;
    mode_d      = video_mode;
    hs_d        = 1'b0;
    vs_d        = 1'b0;
    oe_d        = oe_q;
    locked_d    = locked_q;

    if (wcnt_q < EQ_W) begin
      cls = C_EQ;
    end else if (wcnt_q < HS_W) begin
      cls = C_HS;
    end else if (wcnt_q >= BR_W) begin
      cls = C_BROAD;
    end else begin
      cls = C_INV;
    end

    case (pstate_q)
      P_IDLE: begin
        if (!s_sync) begin
          pstate_d    = P_LOW;
          wcnt_d      = 12'd0;
          period_d    = pcnt_q;
          pcnt_d      = 12'd0;
          // The first fall after reset has no preceding fall to measure from.
          period_ok_d = have_fall_q;
          have_fall_d = 1'b1;
        end else begin
          pstate_d = P_IDLE;
        end
      end
      P_LOW: begin
        if (s_sync) begin
          pstate_d = P_IDLE;
          case (cls)
            C_HS: begin
              hs_d = 1'b1;
              // An HS in V_PRE aborts a false vertical start and is judged as an ordinary line.
              if (((vstate_q == V_NORM) || (vstate_q == V_PRE)) && period_ok_q) begin
                if (in_tol) begin
                  lcnt_d   = (lcnt_q >= LOCK_N) ? LOCK_N : lcnt_q + 8'd1;
                  locked_d = (lcnt_d == LOCK_N) ? 1'b1 : locked_q;
                end else begin
                  lcnt_d   = 8'd0;
                  locked_d = 1'b0;
                end
              end else begin
                lcnt_d = lcnt_q;
              end
              vstate_d = V_NORM;
              bcnt_d   = 2'd0;
            end
            C_EQ: begin
              case (vstate_q)
                V_NORM: begin
                  vstate_d = V_PRE;
                  field_d  = field_odd;
                end
                V_BROAD: begin
                  vstate_d = V_NORM;
                  bcnt_d   = 2'd0;
                end
                default: vstate_d = vstate_q;
              endcase
            end
            C_BROAD: begin
              case (vstate_q)
                V_PRE: begin
                  vstate_d = V_BROAD;
                  bcnt_d   = 2'd1;
                end
                V_BROAD: begin
                  if (bcnt_q == 2'd2) begin
                    vs_d     = 1'b1;
                    oe_d     = field_q;
                    vstate_d = V_POST;
                    bcnt_d   = 2'd0;
                  end else begin
                    bcnt_d = bcnt_q + 2'd1;
                  end
                end
                default: vstate_d = vstate_q;
              endcase
            end
            default: pstate_d = P_IDLE;
          endcase
        end else begin
          wcnt_d = (wcnt_q == CNT_MAX) ? wcnt_q : wcnt_q + 12'd1;
        end
      end
      default: pstate_d = P_IDLE;
    endcase

    if (video_mode != mode_q) begin
      lcnt_d   = 8'd0;
      locked_d = 1'b0;
    end else begin
      mode_d = mode_q;
    end

    // Loss of sync: no fall for two nominal lines.
    if (timeout) begin
      lcnt_d   = 8'd0;
      locked_d = 1'b0;
      vstate_d = V_NORM;
      bcnt_d   = 2'd0;
    end else begin
      bcnt_d = bcnt_d;
    end
  end

  always_ff @(posedge clk_in10M or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      pstate_q    <= P_IDLE;
      vstate_q    <= V_NORM;
      wcnt_q      <= 12'd0;
      pcnt_q      <= 12'd0;
      period_q    <= 12'd0;
      have_fall_q <= 1'b0;
      period_ok_q <= 1'b0;
      bcnt_q      <= 2'd0;
      lcnt_q      <= 8'd0;
      field_q     <= 1'b0;
      mode_q      <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      oe_q        <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      sync1_q     <= csync_in;
      sync2_q     <= sync1_q;
      pstate_q    <= pstate_d;
      vstate_q    <= vstate_d;
      wcnt_q      <= wcnt_d;
      pcnt_q      <= pcnt_d;
      period_q    <= period_d;
      have_fall_q <= have_fall_d;
      period_ok_q <= period_ok_d;
      bcnt_q      <= bcnt_d;
      lcnt_q      <= lcnt_d;
      field_q     <= field_d;
      mode_q      <= mode_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      oe_q        <= oe_d;
      locked_q    <= locked_d;
    end
  end

  assign hs_out = hs_q;
  assign vs_out = vs_q;
  assign oe_out = oe_q;
  assign locked = locked_q;
endmodule

// File: tb/tb_tv_sync_sep.sv
// tb_tv_sync_sep: directed self-checking bench for tv_sync_sep (PAL/NTSC lines, vertical
// interval, field parity, lock, timeout, glitches, reset).
module tb_tv_sync_sep;
  logic clk_in10M = 1'b0;
  logic rst_n     = 1'b0;
  logic csync_in  = 1'b1;
  logic video_mode = 1'b0;
  logic hs_out, vs_out, oe_out, locked;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt  = 0;
  int vs_cnt  = 0;
  int lat     = -1;

`ifdef TV_SYNC_GLITCH_FILT_EN
  localparam int EXP_LAT = 6;
  localparam logic EXP_GLITCH_LOCK = 1'b1;
`else
  localparam int EXP_LAT = 3;
  localparam logic EXP_GLITCH_LOCK = 1'b0;
`endif

  tv_sync_sep dut (
    .clk_in10M (clk_in10M),
    .rst_n     (rst_n),
    .csync_in  (csync_in),
    .video_mode(video_mode),
    .hs_out    (hs_out),
    .vs_out    (vs_out),
    .oe_out    (oe_out),
    .locked    (locked)
  );

  always #50 clk_in10M = ~clk_in10M;

  always @(negedge clk_in10M) begin
    if (hs_out === 1'b1) hs_cnt++;
    if (vs_out === 1'b1) vs_cnt++;
  end

  // One low pulse of 'low' clocks within a 'period'-clock slot; records hs_out latency from the rise.
  task automatic pulse(input int low, input int period);
    csync_in = 1'b0;
    repeat (low) @(negedge clk_in10M);
    csync_in = 1'b1;
    lat = -1;
    for (int i = 1; i <= period - low; i++) begin
      @(negedge clk_in10M);
      if (hs_out === 1'b1 && lat < 0) lat = i;
    end
  endtask

  task automatic lines(input int n, input int period);
    for (int i = 0; i < n; i++) pulse(47, period);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk_in10M);
    n_tests++;
    if ({hs_out, vs_out, oe_out, locked} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: hs/vs/oe/locked=%b expected 0000", {hs_out, vs_out, oe_out, locked});
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk_in10M);
    n_tests++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_locked_after_release: locked=%b expected 0", locked);
    end
  endtask

  task automatic test_pal_lines();
    int hs0;
    hs0 = hs_cnt;
    pulse(47, 640);
    n_tests++;
    if (lat !== EXP_LAT) begin
      n_fail++;
      $display("FAIL hs_latency: got %0d clocks expected %0d", lat, EXP_LAT);
    end
    lines(7, 640);
    n_tests++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_after_7_periods: locked=%b expected 0", locked);
    end
    lines(1, 640);
    n_tests++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_after_8_periods: locked=%b expected 1", locked);
    end
    lines(11, 640);
    n_tests++;
    if (hs_cnt - hs0 !== 20) begin
      n_fail++;
      $display("FAIL pal_hs_count: got %0d expected 20", hs_cnt - hs0);
    end
    n_tests++;
    if (vs_cnt !== 0 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL pal_vs_lock: vs_cnt=%0d locked=%b expected 0 and 1", vs_cnt, locked);
    end
  endtask

  task automatic test_vertical_odd();
    int vs0, hs0;
    lines(2, 640);
    vs0 = vs_cnt;
    hs0 = hs_cnt;
    for (int i = 0; i < 5; i++) pulse(23, 320);
    pulse(270, 320);
    pulse(270, 320);
    n_tests++;
    if (vs_cnt - vs0 !== 0) begin
      n_fail++;
      $display("FAIL vs_before_3rd_broad: got %0d pulses expected 0", vs_cnt - vs0);
    end
    pulse(270, 320);
    n_tests++;
    if (vs_cnt - vs0 !== 1) begin
      n_fail++;
      $display("FAIL vs_on_3rd_broad: got %0d pulses expected 1", vs_cnt - vs0);
    end
    pulse(270, 320);
    pulse(270, 320);
    for (int i = 0; i < 5; i++) pulse(23, 320);
    lines(2, 640);
    n_tests++;
    if (vs_cnt - vs0 !== 1 || oe_out !== 1'b1) begin
      n_fail++;
      $display("FAIL odd_field: vs=%0d oe=%b expected 1 and 1", vs_cnt - vs0, oe_out);
    end
    n_tests++;
    if (locked !== 1'b1 || hs_cnt - hs0 !== 2) begin
      n_fail++;
      $display("FAIL odd_lock_hs: locked=%b hs=%0d expected 1 and 2", locked, hs_cnt - hs0);
    end
  endtask

  task automatic test_vertical_even();
    int vs0;
    lines(1, 640);
    vs0 = vs_cnt;
    pulse(47, 320);
    for (int i = 0; i < 5; i++) pulse(23, 320);
    for (int i = 0; i < 5; i++) pulse(270, 320);
    for (int i = 0; i < 5; i++) pulse(23, 320);
    lines(2, 640);
    n_tests++;
    if (vs_cnt - vs0 !== 1 || oe_out !== 1'b0) begin
      n_fail++;
      $display("FAIL even_field: vs=%0d oe=%b expected 1 and 0", vs_cnt - vs0, oe_out);
    end
    n_tests++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL even_lock: locked=%b expected 1", locked);
    end
  endtask

  task automatic test_glitch();
    int hs0;
    hs0 = hs_cnt;
    pulse(47, 347);
    pulse(2, 293);
    pulse(47, 640);
    n_tests++;
    if (locked !== EXP_GLITCH_LOCK) begin
      n_fail++;
      $display("FAIL glitch_lock: locked=%b expected %b", locked, EXP_GLITCH_LOCK);
    end
    n_tests++;
    if (hs_cnt - hs0 !== 2) begin
      n_fail++;
      $display("FAIL glitch_hs_count: got %0d expected 2", hs_cnt - hs0);
    end
    lines(9, 640);
    n_tests++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_relock: locked=%b expected 1", locked);
    end
  endtask

  task automatic test_timeout();
    csync_in = 1'b0;
    repeat (47) @(negedge clk_in10M);
    csync_in = 1'b1;
    repeat (1250 - 47) @(negedge clk_in10M);
    n_tests++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_early: locked=%b expected 1 at 1250 clk", locked);
    end
    repeat (50) @(negedge clk_in10M);
    n_tests++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_drop: locked=%b expected 0 at 1300 clk", locked);
    end
    lines(9, 640);
    n_tests++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_relock: locked=%b expected 1", locked);
    end
  endtask

  task automatic test_mode_and_reset();
    video_mode = 1'b1;
    @(negedge clk_in10M);
    @(negedge clk_in10M);
    n_tests++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL ntsc_switch_clears: locked=%b expected 0", locked);
    end
    lines(8, 635);
    n_tests++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL ntsc_lock: locked=%b expected 1", locked);
    end
    video_mode = 1'b0;
    @(negedge clk_in10M);
    @(negedge clk_in10M);
    n_tests++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL pal_switch_clears: locked=%b expected 0", locked);
    end
    lines(7, 640);
    n_tests++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL pal_relock_7: locked=%b expected 0", locked);
    end
    lines(1, 640);
    n_tests++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL pal_relock_8: locked=%b expected 1", locked);
    end
    csync_in = 1'b0;
    repeat (20) @(negedge clk_in10M);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({hs_out, vs_out, oe_out, locked} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid_hsync: hs/vs/oe/locked=%b expected 0000", {hs_out, vs_out, oe_out, locked});
    end
    repeat (3) @(negedge clk_in10M);
    csync_in = 1'b1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk_in10M);
  endtask

  initial begin
    @(negedge clk_in10M);
    test_reset();
    test_pal_lines();
    test_vertical_odd();
    test_vertical_even();
    test_glitch();
    test_timeout();
    test_mode_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
